// File: rtl/data_in_pad_pkg.sv
// Shared accelerator package: default parameters, FSM encoding and sizing helper
// used by the padded tile reader and its output FIFO.
package data_in_pad_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DIM_W  = 8;
  localparam int DEF_FIFO_D = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } pad_state_e;

  // Width needed to hold an occupancy count of 0..depth.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pad_fifo.sv
// Small register FIFO holding {pad, last, data} entries for the tile reader.
// The producer never pushes into a full FIFO, so overflow is not handled here.
module pad_fifo
  import data_in_pad_pkg::*;
#(
  parameter int W = DEF_DATA_W + 2,
  parameter int D = DEF_FIFO_D
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_i,
  input  logic [W-1:0]          push_data_i,
  input  logic                  pop_i,
  output logic [W-1:0]          head_o,
  output logic                  empty_o,
  output logic [cnt_w(D)-1:0]   count_o
);

  localparam int CW = cnt_w(D);
  localparam int PW = (D > 1) ? $clog2(D) : 1;

  logic [W-1:0]  mem_q [D];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_pop_s;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(D - 1)) begin
      return '0;
    end else begin
      return p + PW'(1);
    end
  endfunction

  assign do_pop_s = pop_i && (count_q != '0);

  // Storage, pointers and occupancy; push+pop together leaves the count unchanged.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < D; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (do_pop_s) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      if (push_i && !do_pop_s) begin
        count_q <= count_q + CW'(1);
      end else if (!push_i && do_pop_s) begin
        count_q <= count_q - CW'(1);
      end
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/data_in_pad.sv
// Tile reader that scans a zero-padded (H+2P)x(W+2P) grid in raster order,
// fetching interior elements from memory and emitting a flagged element stream.
module data_in_pad
  import data_in_pad_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DIM_W  = DEF_DIM_W,
  parameter int FIFO_D = DEF_FIFO_D
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DIM_W-1:0]  cfg_w,
  input  logic [DIM_W-1:0]  cfg_h,
  input  logic [1:0]        cfg_pad,
  input  logic [ADDR_W-1:0] cfg_base,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_pad,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = DIM_W + 2;
  localparam int CW    = cnt_w(FIFO_D);
  localparam int FW    = DATA_W + 2;

  pad_state_e        state_q, state_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [CNT_W-1:0]  r_q, c_q;
  logic [CNT_W-1:0]  rows_q, cols_q, p_q, w_end_q, h_end_q;
  logic [ADDR_W-1:0] ptr_q;
  logic              stage_valid_q, stage_pad_q, stage_last_q;

  logic [CNT_W-1:0]  cfg_w_s, cfg_h_s, cfg_p_s;
  logic              start_s, zero_job_s, issue_s, interior_s, last_s, pop_s;
  logic [CW:0]       occ_s;
  logic [CW-1:0]     fifo_count_s;
  logic              fifo_empty_s;
  logic [FW-1:0]     push_data_s;
  logic [FW-1:0]     head_s;

  assign cfg_w_s    = CNT_W'(cfg_w);
  assign cfg_h_s    = CNT_W'(cfg_h);
  assign cfg_p_s    = CNT_W'(cfg_pad);
  assign start_s    = (state_q == ST_IDLE) && start;
  assign zero_job_s = (cfg_w == '0) || (cfg_h == '0);

  // The stage slot counts as occupied so an issued element always finds room.
  assign occ_s      = (CW + 1)'(fifo_count_s) + (CW + 1)'(stage_valid_q);
  assign issue_s    = (state_q == ST_RUN) && (occ_s < (CW + 1)'(FIFO_D));
  assign interior_s = (r_q >= p_q) && (r_q < h_end_q) && (c_q >= p_q) && (c_q < w_end_q);
  assign last_s     = (r_q == rows_q - CNT_W'(1)) && (c_q == cols_q - CNT_W'(1));
  assign pop_s      = !fifo_empty_s && out_ready;

  assign mem_re   = issue_s && interior_s;
  assign mem_addr = mem_re ? ptr_q : '0;

  // Next-state logic; a zero-sized job completes straight from IDLE.
  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && zero_job_s) begin
          done_d = 1'b1;
        end else if (start) begin
          state_d = ST_RUN;
          busy_d  = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (issue_s && last_s) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (pop_s && head_s[DATA_W]) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Job register, raster counters and the interior address pointer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q     <= '0;
      c_q     <= '0;
      rows_q  <= '0;
      cols_q  <= '0;
      p_q     <= '0;
      w_end_q <= '0;
      h_end_q <= '0;
      ptr_q   <= '0;
    end else if (start_s) begin
      r_q     <= '0;
      c_q     <= '0;
      p_q     <= cfg_p_s;
      w_end_q <= cfg_w_s + cfg_p_s;
      h_end_q <= cfg_h_s + cfg_p_s;
      cols_q  <= cfg_w_s + (cfg_p_s << 1);
      rows_q  <= cfg_h_s + (cfg_p_s << 1);
      ptr_q   <= cfg_base;
    end else if (issue_s) begin
      if (c_q == cols_q - CNT_W'(1)) begin
        c_q <= '0;
        r_q <= r_q + CNT_W'(1);
      end else begin
        c_q <= c_q + CNT_W'(1);
      end
      // Interior elements are contiguous in raster order, so +1 suffices.
      if (interior_s) begin
        ptr_q <= ptr_q + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stage_valid_q <= 1'b0;
      stage_pad_q   <= 1'b0;
      stage_last_q  <= 1'b0;
    end else begin
      stage_valid_q <= issue_s;
      stage_pad_q   <= issue_s && !interior_s;
      stage_last_q  <= issue_s && last_s;
    end
  end

  assign push_data_s = {stage_pad_q, stage_last_q, (stage_pad_q ? {DATA_W{1'b0}} : mem_rdata)};

  pad_fifo #(
    .W (FW),
    .D (FIFO_D)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (stage_valid_q),
    .push_data_i (push_data_s),
    .pop_i       (pop_s),
    .head_o      (head_s),
    .empty_o     (fifo_empty_s),
    .count_o     (fifo_count_s)
  );

  assign out_valid = !fifo_empty_s;
  assign out_data  = fifo_empty_s ? {DATA_W{1'b0}} : head_s[DATA_W-1:0];
  assign out_last  = !fifo_empty_s && head_s[DATA_W];
  assign out_pad   = !fifo_empty_s && head_s[DATA_W+1];
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_data_in_pad.sv
// Directed bench for data_in_pad: memory returns its address as data, and a
// small raster model supplies the expected element stream for each job.
module tb_data_in_pad;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  cfg_w = 8'd0, cfg_h = 8'd0;
  logic [1:0]  cfg_pad = 2'd0;
  logic [15:0] cfg_base = 16'd0;
  logic        mem_re;
  logic [15:0] mem_addr;
  logic [31:0] mem_rdata = 32'hDEAD_BEEF;
  logic        out_valid, out_ready = 1'b1;
  logic [31:0] out_data;
  logic        out_pad, out_last, busy, done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] o_data[$], e_data[$];
  bit          o_pad[$], e_pad[$], o_last[$], e_last[$];
  logic [15:0] a_obs[$], e_addr[$];
  int done_cyc, last_pop, done_cnt, stall_err, busy1;

  data_in_pad dut (
    .clk(clk), .rst(rst), .start(start), .cfg_w(cfg_w), .cfg_h(cfg_h),
    .cfg_pad(cfg_pad), .cfg_base(cfg_base), .mem_re(mem_re), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_pad(out_pad), .out_last(out_last),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_re) mem_rdata <= {16'h0000, mem_addr};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_mem_re"}, 32'(mem_re), 32'd0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_pad"}, 32'(out_pad), 32'd0);
    chk({tag, "_last"}, 32'(out_last), 32'd0);
    chk({tag, "_data"}, out_data, 32'd0);
  endtask

  task automatic build_exp(input int w, input int h, input int p, input logic [15:0] base);
    bit          in_s;
    logic [15:0] a;
    e_data.delete(); e_pad.delete(); e_last.delete(); e_addr.delete();
    if (w != 0 && h != 0) begin
      for (int r = 0; r < h + 2 * p; r++) begin
        for (int c = 0; c < w + 2 * p; c++) begin
          in_s = (r >= p) && (r < h + p) && (c >= p) && (c < w + p);
          a    = base + 16'((r - p) * w + (c - p));
          e_pad.push_back(!in_s);
          e_data.push_back(in_s ? {16'h0000, a} : 32'd0);
          e_last.push_back((r == h + 2 * p - 1) && (c == w + 2 * p - 1));
          if (in_s) e_addr.push_back(a);
        end
      end
    end
  endtask

  task automatic run_job(input int w, input int h, input int p, input logic [15:0] base,
                         input bit tog, input int inj, input int stop_after, input int max_cyc);
    bit pv, pr, ppad, plast;
    logic [31:0] pd;
    o_data.delete(); o_pad.delete(); o_last.delete(); a_obs.delete();
    done_cyc = -1; last_pop = -1; done_cnt = 0; stall_err = 0; busy1 = -1;
    pv = 1'b0; pr = 1'b1; pd = 32'd0; ppad = 1'b0; plast = 1'b0;
    @(negedge clk);
    cfg_w = 8'(w); cfg_h = 8'(h); cfg_pad = 2'(p); cfg_base = base;
    start = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 1; cyc <= max_cyc; cyc++) begin
      out_ready = tog ? (((cyc - 1) % 4 == 0) || ((cyc - 1) % 4 == 3)) : 1'b1;
      if (cyc == inj) begin
        start = 1'b1; cfg_w = 8'd5; cfg_h = 8'd3; cfg_pad = 2'd0; cfg_base = 16'h0000;
      end else begin
        start = 1'b0;
      end
      if (cyc == 1) busy1 = int'(busy);
      if (mem_re) a_obs.push_back(mem_addr);
      if (pv && !pr) begin
        if (!out_valid || out_data !== pd || out_pad !== ppad || out_last !== plast) stall_err++;
      end
      pv = out_valid; pr = out_ready; pd = out_data; ppad = out_pad; plast = out_last;
      if (out_valid && out_ready) begin
        o_data.push_back(out_data); o_pad.push_back(out_pad); o_last.push_back(out_last);
        if (out_last) last_pop = cyc;
      end
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
        chk("busy_at_done", 32'(busy), 32'd0);
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
      if (stop_after > 0 && o_data.size() >= stop_after) break;
      @(negedge clk);
    end
    start = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic compare_job(input string tag);
    int n;
    chk({tag, "_count"}, 32'(o_data.size()), 32'(e_data.size()));
    n = (o_data.size() < e_data.size()) ? o_data.size() : e_data.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_data%0d", tag, i), o_data[i], e_data[i]);
      chk($sformatf("%s_pad%0d", tag, i), 32'(o_pad[i]), 32'(e_pad[i]));
      chk($sformatf("%s_last%0d", tag, i), 32'(o_last[i]), 32'(e_last[i]));
    end
    chk({tag, "_nre"}, 32'(a_obs.size()), 32'(e_addr.size()));
    n = (a_obs.size() < e_addr.size()) ? a_obs.size() : e_addr.size();
    for (int i = 0; i < n; i++) chk($sformatf("%s_addr%0d", tag, i), 32'(a_obs[i]), 32'(e_addr[i]));
    chk({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
    chk({tag, "_done_cyc"}, 32'(done_cyc), 32'(last_pop + 1));
    chk({tag, "_busy1"}, 32'(busy1), 32'd1);
  endtask

  initial begin
    int ndone;
    #1;
    chk_reset("rst");
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // 2x2 tile, one ring of padding, always ready.
    build_exp(2, 2, 1, 16'h0100);
    run_job(2, 2, 1, 16'h0100, 1'b0, 0, 0, 300);
    compare_job("A");
    if (o_data.size() == 16) begin
      chk("A_pos5", o_data[5], 32'h0000_0100);
      chk("A_pos10", o_data[10], 32'h0000_0103);
      chk("A_last15", 32'(o_last[15]), 32'd1);
    end else begin
      chk("A_size16", 32'(o_data.size()), 32'd16);
    end

    // Unpadded tile whose addresses wrap past 0xFFFF.
    build_exp(3, 2, 0, 16'hFFFE);
    run_job(3, 2, 0, 16'hFFFE, 1'b0, 0, 0, 300);
    compare_job("B");
    if (a_obs.size() == 6) begin
      chk("B_addr1", 32'(a_obs[1]), 32'h0000_FFFF);
      chk("B_addr2", 32'(a_obs[2]), 32'h0000_0000);
    end else begin
      chk("B_size6", 32'(a_obs.size()), 32'd6);
    end

    // Same as A with back-pressure and an ignored start mid-job.
    build_exp(2, 2, 1, 16'h0100);
    run_job(2, 2, 1, 16'h0100, 1'b1, 5, 0, 600);
    compare_job("C");
    chk("C_stall_stable", 32'(stall_err), 32'd0);

    // Zero-width job: immediate done, no traffic.
    run_job(0, 5, 2, 16'h0040, 1'b0, 0, 0, 10);
    chk("D_outputs", 32'(o_data.size()), 32'd0);
    chk("D_mem_re", 32'(a_obs.size()), 32'd0);
    chk("D_done_cyc", 32'(done_cyc), 32'd1);
    chk("D_done_cnt", 32'(done_cnt), 32'd1);

    // Reset after the 7th output of a 4x4 padded job.
    run_job(4, 4, 1, 16'h0200, 1'b0, 0, 7, 300);
    chk("E_seven", 32'(o_data.size()), 32'd7);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_reset("E_rst");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("E_no_done", 32'(ndone), 32'd0);
    chk("E_idle_busy", 32'(busy), 32'd0);

    // Fresh single-element job after the abandoned one.
    build_exp(1, 1, 0, 16'h0020);
    run_job(1, 1, 0, 16'h0020, 1'b0, 0, 0, 100);
    compare_job("F");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
